// File: rtl/imem_loader_if.sv
// Byte-stream input and BRAM write port of the instruction-memory loader.
// The master side is the loader; the slave side is the byte source plus the BRAM.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output bram_we,
    output bram_addr,
    output bram_din
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  bram_we,
    input  bram_addr,
    input  bram_din
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs little-endian words into the
// instruction BRAM and holds the core in reset until a clean load. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  imem_loader_if.master bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cpu_rst_n_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_e;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_w;

  // rx_ready is the registered busy flag, so a byte is taken whenever the FSM is loading.
  assign accept = bus.rx_valid && busy_q;
  assign len_w  = {bus.rx_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_m1_d    = len_m1_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = LEN_LO;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_rst_n_d = 1'b0;
          byte_cnt_d  = 2'd0;
          word_cnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = 8'd0;
`endif
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          if (len_w == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d     = CSUM;
`else
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
`endif
          end else if ({1'b0, len_w} > MAX_WORDS) begin
            // Image cannot fit: fail without touching the BRAM; core stays in reset.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            len_m1_d = ADDR_W'(len_w - 16'd1);
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            din_d      = {bus.rx_data, asm_q};
            addr_d     = word_cnt_q;
            word_cnt_d = word_cnt_q + ADDR_W'(1);
            if (word_cnt_q == len_m1_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d     = CSUM;
`else
              state_d     = DONE;
              done_d      = 1'b1;
              cpu_rst_n_d = 1'b1;
`endif
            end
          end else begin
            // Shift right so byte 0 ends up in the lowest lane after three bytes.
            asm_d = {bus.rx_data, asm_q[23:8]};
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d     = DONE;
          done_d      = 1'b1;
          err_d       = (bus.rx_data != csum_q);
          cpu_rst_n_d = (bus.rx_data == csum_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == CSUM) busy_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_lo_q    <= 8'd0;
      len_m1_q    <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 24'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_m1_q    <= len_m1_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = busy_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cpu_rst_n_o   = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected BRAM writes, a negedge
// monitor pops and compares them; load status is checked one cycle after the last byte.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, cpu_rst_n;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .cpu_rst_n_o(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  tx_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bus.bram_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h din=%h want no write", bus.bram_addr, bus.bram_din);
      end else begin
        $display("write addr=%0h din=%h", bus.bram_addr, bus.bram_din);
        chk("write", 64'({bus.bram_addr, bus.bram_din}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic add_len(input logic [15:0] n);
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
  endtask

  task automatic push_word(input logic [7:0] addr, input logic [31:0] w);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[31:24]);
    exp_q.push_back({addr, w});
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    for (int i = 2; i < tx_q.size(); i++) x ^= tx_q[i];
    tx_q.push_back(x);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_done", done, 1'b0);
    chk1("start_err", err, 1'b0);
    chk1("start_cpu_rst_n", cpu_rst_n, 1'b0);
  endtask

  task automatic send_all(input int gap_max);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == tx_q.size() - 1) chk1("done_before_last", done, 1'b0);
      bus.rx_data  = tx_q[i];
      bus.rx_valid = 1'b1;
      chk1("rx_ready", bus.rx_ready, 1'b1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (i != tx_q.size() - 1) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          chk1("busy_gap", busy, 1'b1);
        end
      end
    end
    tx_q.delete();
  endtask

  task automatic check_end(input string tag, input logic e_err, input logic e_cpu);
    $display("load %s: done=%b err=%b cpu_rst_n=%b", tag, done, err, cpu_rst_n);
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_err"}, err, e_err);
    chk1({tag, "_cpu_rst_n"}, cpu_rst_n, e_cpu);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, 64'({bus.rx_ready, bus.bram_we, bus.bram_addr, bus.bram_din,
                  busy, done, err, cpu_rst_n}), 64'd0);
  endtask

  task automatic basic_stream();
    add_len(16'd2);
    push_word(8'd0, 32'h12345678);
    push_word(8'd1, 32'hDEADBEEF);
    add_csum();
  endtask

  initial begin
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("idle_outs");

    // Basic two-word load
    basic_stream();
    do_start();
    send_all(0);
    check_end("basic", 1'b0, 1'b1);

    // Bytes offered in DONE must be ignored
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk1("done_rx_ready", bus.rx_ready, 1'b0);
      chk1("done_hold", done, 1'b1);
    end
    bus.rx_valid = 1'b0;

    // Gapped stream, restarted from DONE
    basic_stream();
    do_start();
    send_all(5);
    check_end("gapped", 1'b0, 1'b1);

    // Oversize length: nothing written, core kept in reset
    add_len(16'h0101);
    do_start();
    send_all(0);
    check_end("oversize", 1'b1, 1'b0);

    // Zero length
    add_len(16'd0);
    add_csum();
    do_start();
    send_all(0);
    check_end("zero", 1'b0, 1'b1);

    // Full depth: 256 words, address runs 0..255
    add_len(16'd256);
    for (int i = 0; i < 256; i++)
      push_word(8'(i), {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'h3C});
    add_csum();
    do_start();
    send_all(0);
    check_end("full", 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    add_len(16'd1);
    push_word(8'd0, 32'h44332211);
    tx_q.push_back(8'h44);
    do_start();
    send_all(1);
    check_end("csum_good", 1'b0, 1'b1);

    add_len(16'd1);
    push_word(8'd0, 32'h44332211);
    tx_q.push_back(8'h00);
    do_start();
    send_all(0);
    check_end("csum_bad", 1'b1, 1'b0);
`endif

    // Reset after 6 data bytes: word 0 written, partial word 1 dropped
    add_len(16'd2);
    push_word(8'd0, 32'h12345678);
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    do_start();
    send_all(0);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midload_reset_outs");
    repeat (3) @(negedge clk);
    check_reset_outs("midload_reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("after_reset_idle");

    // Full load after reset, then restart from DONE
    basic_stream();
    do_start();
    send_all(0);
    check_end("post_reset", 1'b0, 1'b1);
    do_start();
    $display("restart from done: done=%b cpu_rst_n=%b", done, cpu_rst_n);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction-memory BRAM. It receives a byte stream over a valid/ready handshake, typically from the boot UART receiver. It assembles the bytes into little-endian 32-bit words and drives the BRAM write port (we/addr/din) with them. The core is held in reset through `cpu_rst_n` until a complete, error-free image has been written. After that the core fetches through the read-only instruction port.

## Interface
- `ADDR_W`, 8, word-address width; depth = 2^ADDR_W words (the BRAM uses byte address bits [9:2])
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse that begins a load; honoured in IDLE and DONE only
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on `rx_valid && rx_ready`
- `bram_we`  out  1  one-cycle BRAM write strobe
- `bram_addr`  out  ADDR_W  word address for the write
- `bram_din`  out  32  write data
- `busy`  out  1  load in progress
- `done`  out  1  load finished (level); valid until the next `start`
- `err`  out  1  load failed; qualified by `done`
- `cpu_rst_n`  out  1  active-low core reset; released only after a clean load

## Operation
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM (only when the macro is defined), DONE.
- IDLE, on `start`: go to LEN_LO. Clear `done` and `err`, drive `cpu_rst_n`=0, clear the byte counter, the word counter and the checksum.
- DONE, on `start`: same action as IDLE. This restarts a load and puts the core back into reset.
- LEN_LO / LEN_HI: accept a 16-bit word count N, little-endian.
- After LEN_HI:
  - N=0: go to CSUM if present, otherwise DONE.
  - N>2^ADDR_W: set `err`=1 and go straight to DONE. Nothing is written.
  - Otherwise: go to DATA.
- DATA: each accepted byte shifts into the assembly register. Byte 0 lands in [7:0] and byte 3 in [31:24].
- On the 4th byte of a word:
  - Next cycle: `bram_we`=1, `bram_din`=the assembled word, `bram_addr`=the word index (0..N-1).
  - The word counter then increments.
- After the 4th byte of word N-1: go to CSUM if present, otherwise DONE.
- DONE: `done`=1. If `err`=0, `cpu_rst_n`=1. If `err`=1, `cpu_rst_n` stays 0.
- `busy`=1 in LEN_LO, LEN_HI, DATA and CSUM.
- `rx_ready`=1 in exactly the same states. Writes never stall the input.
- `start` while `busy`=1 is ignored.
- `rx_valid` outside the busy states is ignored. No byte is consumed.

## Timing
- Reset values of all outputs: `rx_ready`=0, `bram_we`=0, `bram_addr`=0, `bram_din`=0, `busy`=0, `done`=0, `err`=0, `cpu_rst_n`=0.
- All outputs are registered.
- Write latency: `bram_we` is high in the cycle immediately after the 4th byte transfers, for exactly one cycle.
- The BRAM samples on the falling edge of `clk`, so a write lands half a cycle after `bram_we` rises.
- Throughput: one byte per cycle sustained. Back-to-back writes occur every 4 cycles at full rate.
- `rx_valid` gaps of any length are allowed; partial-word state is held across them.
- Last word: `bram_we` and the entry to DONE occur in the same cycle. `done` and `cpu_rst_n` rise together, one cycle after the final accepted byte.
- Reset asserted mid-load:
  - All state returns immediately to the reset values and the FSM goes to IDLE.
  - Words already written remain in the BRAM.
  - Any partially assembled word is discarded and is not written.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last data byte (or after LEN_HI when N=0), the loader accepts one extra byte in CSUM.
  - `err`=1 if that byte differs from the XOR of all data bytes. The length bytes are excluded from the XOR.
  - Then go to DONE.
- Undefined:
  - The CSUM state and the checksum register are absent.
  - The loader goes directly to DONE.
  - `err` is set only by the oversize-length check.

## Test plan
- Basic load (macro off): `start`, then bytes 02 00 78 56 34 12 EF BE AD DE.
  - Expected: writes (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF), each with a one-cycle `bram_we`.
  - Expected: `done`=1, `err`=0, `cpu_rst_n`=1 one cycle after the last byte.
- Gapped stream: same bytes as the basic load, with 0–5 idle cycles of random length between bytes.
  - Expected: identical writes; `busy` is held throughout.
- Oversize length: N=0x0101 with `ADDR_W`=8.
  - Expected: no `bram_we`, `done`=1, `err`=1, `cpu_rst_n`=0.
- Zero length: N=0.
  - Expected: no writes; `done`=1, `cpu_rst_n`=1 (macro on: after a correct checksum byte 00).
- Checksum (macro on): 01 00 11 22 33 44, then 44 gives `err`=0 and 00 gives `err`=1. The write to addr 0 is 0x44332211 in both cases.
- Reset and restart:
  - Assert `rst_n`=0 after 6 data bytes. Expected: all outputs return to reset values and there is no write of word 1.
  - Then `start` a full load. Expected: completes normally.
  - Then `start` while in DONE. Expected: `cpu_rst_n` drops to 0 and `done` clears.
